// File: rtl/core_pkg.sv
// Shared RV32I core types: fetch FSM states, bubble word, opcodes, address helpers.
// Pure declarations; no timing or flow control of its own.
package core_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [6:0] opcode_of(input logic [31:0] instr);
    return instr[6:0];
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry {instr, pc} buffer catching a word fetched while decode is stalled.
// Loads/clears on the clock edge; clear wins over load.
module fetch_skid_reg
  import core_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  fetch_word_t entry;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      entry <= '{instr: NOP_INSTR, pc: 32'h0};
      valid <= 1'b0;
    end else if (clear) begin
      entry <= '{instr: NOP_INSTR, pc: 32'h0};
      valid <= 1'b0;
    end else if (load) begin
      entry <= '{instr: load_instr, pc: load_pc};
      valid <= 1'b1;
    end
  end

  assign instr = entry.instr;
  assign pc    = entry.pc;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch: PC, single-outstanding imem req/ack, IF/ID register; 1 instr/cycle with same-cycle ack.
// Decode stall parks one word in a skid; redirect flushes IF/ID and discards any in-flight fetch.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  drop_addr;
  logic         accept;
  logic         fetch_ack;
  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc;

  assign imem_req  = (state == S_FETCH) || (state == S_DROP);
  assign imem_addr = (state == S_DROP) ? drop_addr : pc;

  // An empty IF/ID slot always fills, so stall only matters once it holds a real instruction.
  assign accept    = !stall || !id_valid;
  assign fetch_ack = (state == S_FETCH) && imem_ack;

  assign skid_load  = !redirect && fetch_ack && !accept;
  assign skid_clear = redirect || ((state == S_HOLD) && !stall);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect) begin
      pc_nxt = align_word(redirect_pc);
      unique case (state)
        S_IDLE:  state_nxt = S_FETCH;
        S_FETCH: state_nxt = imem_ack ? S_FETCH : S_DROP;
        S_HOLD:  state_nxt = S_FETCH;
        S_DROP:  state_nxt = S_DROP;
        default: state_nxt = S_IDLE;
      endcase
    end else begin
      unique case (state)
        S_IDLE:  state_nxt = S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            pc_nxt    = pc + INSTR_BYTES;
            state_nxt = accept ? S_FETCH : S_HOLD;
          end
        end
        S_HOLD:  if (!stall) state_nxt = S_FETCH;
        S_DROP:  if (imem_ack) state_nxt = S_FETCH;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // The abandoned request keeps its address on the bus until memory acks it.
      if (redirect && (state == S_FETCH) && !imem_ack)
        drop_addr <= pc;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      id_instr <= NOP_INSTR;
      id_pc    <= 32'h0;
      id_pc4   <= 32'h0;
      id_valid <= 1'b0;
    end else if (redirect) begin
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (accept) begin
            if (imem_ack) begin
              id_instr <= imem_rdata;
              id_pc    <= pc;
              id_pc4   <= pc + INSTR_BYTES;
              id_valid <= 1'b1;
            end else begin
              id_valid <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (!stall && skid_valid) begin
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
            id_pc4   <= skid_pc + INSTR_BYTES;
            id_valid <= 1'b1;
          end
        end
        S_DROP:  id_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  fetch_skid_reg u_skid (
    .CLK        (CLK),
    .RST        (RST),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .instr      (skid_instr),
    .pc         (skid_pc),
    .valid      (skid_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with programmable ack latency, rdata = addr + 0x100.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic        id_valid;

  int   ack_lat = 0;
  int   wait_cnt = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  fetch_stage dut (
    .CLK         (CLK),
    .RST         (RST),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid)
  );

  always #5 CLK = ~CLK;

  assign imem_ack   = imem_req && (wait_cnt >= ack_lat);
  assign imem_rdata = imem_addr + 32'h100;

  always @(posedge CLK) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RST = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_lat = 0;
    sb.delete();
    tick; tick;
    RST = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (id_valid !== 1'b1 && n < budget) begin tick; n++; end
    if (id_valid !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: id_valid=%b after %0d cycles, need 1", tag, id_valid, budget);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    vectors++; if (id_instr !== 32'h13) begin miscompares++; $display("FAIL reset_instr: got %h want 00000013", id_instr); end
    vectors++; if (id_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", id_pc); end
    vectors++; if (id_pc4 !== 32'h0) begin miscompares++; $display("FAIL reset_pc4: got %h want 0", id_pc4); end
    vectors++; if (id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", id_valid); end
  endtask

  task automatic test_stream;
    exp_t e;
    do_reset;
    for (int i = 0; i < 3; i++) sb.push_back('{instr: 32'h100 + 32'(i * 4), pc: 32'(i * 4)});
    wait_valid("stream", 10);
    for (int k = 0; k < 3; k++) begin
      if (sb.size() == 0) break;
      e = sb.pop_front();
      vectors++; if (id_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", k, id_valid); end
      vectors++; if (id_instr !== e.instr) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h want %h", k, id_instr, e.instr); end
      vectors++; if (id_pc !== e.pc) begin miscompares++; $display("FAIL stream_pc[%0d]: got %h want %h", k, id_pc, e.pc); end
      vectors++; if (id_pc4 !== e.pc + 32'd4) begin miscompares++; $display("FAIL stream_pc4[%0d]: got %h want %h", k, id_pc4, e.pc + 32'd4); end
      vectors++; if (imem_addr !== e.pc + 32'd4) begin miscompares++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, e.pc + 32'd4); end
      tick;
    end
  endtask

  task automatic test_stall;
    exp_t e;
    do_reset;
    wait_valid("stall", 10);
    stall = 1'b1;
    sb.push_back('{instr: 32'h104, pc: 32'h4});
    sb.push_back('{instr: 32'h108, pc: 32'h8});
    for (int k = 0; k < 3; k++) begin
      tick;
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); end
      vectors++; if (id_instr !== 32'h100 || id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold[%0d]: got %h/%b want 00000100/1", k, id_instr, id_valid); end
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      e = sb.pop_front();
      vectors++; if (id_instr !== e.instr || id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_resume_instr[%0d]: got %h/%b want %h/1", k, id_instr, id_valid, e.instr); end
      vectors++; if (id_pc !== e.pc || id_pc4 !== e.pc + 32'd4) begin miscompares++; $display("FAIL stall_resume_pc[%0d]: got %h/%h want %h/%h", k, id_pc, id_pc4, e.pc, e.pc + 32'd4); end
      vectors++; if (imem_req !== 1'b1 || imem_addr !== e.pc + 32'd4) begin miscompares++; $display("FAIL stall_resume_addr[%0d]: got %b/%h want 1/%h", k, imem_req, imem_addr, e.pc + 32'd4); end
    end
  endtask

  task automatic test_redirect_drop;
    exp_t e;
    int   n;
    bit   seen_ack, done;
    do_reset;
    ack_lat = 2;
    n = 0;
    while (!(imem_req === 1'b1 && imem_addr === 32'h8) && n < 30) begin tick; n++; end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL drop_setup: got req=%b addr=%h want 1/00000008", imem_req, imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0203;
    tick;
    redirect = 1'b0;
    seen_ack = 0; done = 0; n = 0;
    while (!done && n < 20) begin
      vectors++; if (id_valid !== 1'b0 || id_instr !== 32'h13) begin miscompares++; $display("FAIL drop_bubble[%0d]: got %b/%h want 0/00000013", n, id_valid, id_instr); end
      if (imem_req === 1'b1) begin
        if (!seen_ack) begin
          vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL drop_addr_stable[%0d]: got %h want 00000008", n, imem_addr); end
          if (imem_ack === 1'b1) seen_ack = 1;
        end else begin
          vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL drop_refetch_addr: got %h want 00000200", imem_addr); end
          done = 1;
        end
      end
      if (!done) begin tick; n++; end
    end
    if (!done) begin vectors++; miscompares++; $display("FAIL drop_timeout: seen_ack=%b, need refetch at 00000200", seen_ack); end
    sb.push_back('{instr: 32'h300, pc: 32'h200});
    wait_valid("drop_first", 10);
    e = sb.pop_front();
    vectors++; if (id_instr !== e.instr || id_pc !== e.pc) begin miscompares++; $display("FAIL drop_first_word: got %h@%h want %h@%h", id_instr, id_pc, e.instr, e.pc); end
  endtask

  task automatic test_redirect_hold;
    exp_t e;
    do_reset;
    wait_valid("rhold", 10);
    stall = 1'b1;
    tick;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rhold_in_hold: req got %b want 0", imem_req); end
    redirect = 1'b1; redirect_pc = 32'h400;
    tick;
    redirect = 1'b0;
    vectors++; if (id_valid !== 1'b0 || id_instr !== 32'h13) begin miscompares++; $display("FAIL rhold_flush: got %b/%h want 0/00000013", id_valid, id_instr); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin miscompares++; $display("FAIL rhold_target: got %b/%h want 1/00000400", imem_req, imem_addr); end
    sb.push_back('{instr: 32'h500, pc: 32'h400});
    tick;
    e = sb.pop_front();
    vectors++; if (id_valid !== 1'b1 || id_instr !== e.instr || id_pc !== e.pc) begin miscompares++; $display("FAIL rhold_fill_under_stall: got %b %h@%h want 1 %h@%h", id_valid, id_instr, id_pc, e.instr, e.pc); end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n = 0;
    do_reset;
    ack_lat = 2; stall = 1'b1;
    while (!(id_valid === 1'b1 && imem_req === 1'b1) && n < 20) begin tick; n++; end
    vectors++; if (id_valid !== 1'b1 || imem_req !== 1'b1) begin miscompares++; $display("FAIL rmid_setup: got valid=%b req=%b want 1/1", id_valid, imem_req); end
    #2 RST = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b0 || id_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_async: got req=%b valid=%b want 0/0", imem_req, id_valid); end
    vectors++; if (id_instr !== 32'h13 || id_pc !== 32'h0 || id_pc4 !== 32'h0) begin miscompares++; $display("FAIL rmid_regs: got %h %h %h want 00000013 0 0", id_instr, id_pc, id_pc4); end
    tick;
    RST = 1'b0; ack_lat = 0; stall = 1'b0;
    n = 0;
    while (imem_req !== 1'b1 && n < 5) begin tick; n++; end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_first_fetch: got %b/%h want 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    exp_t e;
    do_reset;
    wait_valid("wrap", 10);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick;
    redirect = 1'b0;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC || id_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_target: got %h/%b want fffffffc/0", imem_addr, id_valid); end
    sb.push_back('{instr: 32'h0000_00FC, pc: 32'hFFFF_FFFC});
    sb.push_back('{instr: 32'h0000_0100, pc: 32'h0});
    for (int k = 0; k < 2; k++) begin
      tick;
      e = sb.pop_front();
      vectors++; if (id_instr !== e.instr || id_pc !== e.pc) begin miscompares++; $display("FAIL wrap_word[%0d]: got %h@%h want %h@%h", k, id_instr, id_pc, e.instr, e.pc); end
      vectors++; if (id_pc4 !== e.pc + 32'd4) begin miscompares++; $display("FAIL wrap_pc4[%0d]: got %h want %h", k, id_pc4, e.pc + 32'd4); end
      vectors++; if (imem_addr !== e.pc + 32'd4) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h want %h", k, imem_addr, e.pc + 32'd4); end
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_redirect_drop;
    test_redirect_hold;
    test_reset_mid;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
